posit_special_core: RTL and testbench

POSIT_SPECIAL_CORE -- requirements
Module: posit_special_core

---
 rtl/posit_special_core.sv | 183 ++++++++++++++++++
 tb/tb_posit_special_core.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/posit_special_core.sv
// posit_special_core: special-value detection and unnormalized arithmetic core
// for posit add/sub/mul/div. One registered stage; data outputs hold while idle.
// Optional feature macro: POSIT_CORE_DIV_EN builds the mantissa divider. When it
// is not defined, op=11 is reported as a special case returning NaR.
module posit_special_core #(
  parameter int N  = 16,
  parameter int ES = 1,
  localparam int M  = N - 2,
  localparam int TE = ES + $clog2(N) + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [N-1:0]         p1,
  input  logic [N-1:0]         p2,
  input  logic [1:0]           op,
  input  logic signed [TE-1:0] te1,
  input  logic signed [TE-1:0] te2,
  input  logic [M-1:0]         mant1,
  input  logic [M-1:0]         mant2,
  output logic                 out_valid,
  output logic                 is_special,
  output logic [N-1:0]         pout_special,
  output logic                 sign_out,
  output logic signed [TE:0]   te_out,
  output logic [2*M-1:0]       mant_out
);

  localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};
  localparam int           SW     = TE + 1;
  localparam logic [TE:0]  SH_LIM = SW'(2*M);

  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_e;

  typedef struct packed {
    logic                 spec;
    logic [N-1:0]         pout;
    logic                 sgn;
    logic signed [TE:0]   te;
    logic [2*M-1:0]       mant;
  } res_t;

  op_e  op_s;
  assign op_s = op_e'(op);

  logic         s1, s2;
  logic         p1_zero, p2_zero, p1_nar, p2_nar;
  logic         spec_c;
  logic [N-1:0] pout_c;

  logic signed [TE:0] te1x, te2x, ted, te_big;
  logic [TE:0]        shamt;
  logic               op1_big, eff_add;
  logic [2*M-1:0]     ext1, ext2, big, sml, sml_sh, prod;
  logic               sgn_c;
  logic signed [TE:0] te_c;
  logic [2*M-1:0]     mant_c;

`ifdef POSIT_CORE_DIV_EN
  logic [3*M-3:0] dividend, divisor, quot;
  logic           div_unused;
  assign div_unused = ^quot[3*M-3:2*M];
`endif

  res_t res_d, res_q;
  logic vld_d, vld_q;

  assign s1 = p1[N-1];
  assign s2 = p2[N-1];

  // Zero/NaR detection and the special-case result chosen by priority
  always_comb begin
    p1_zero = (p1 == '0);
    p2_zero = (p2 == '0);
    p1_nar  = (p1 == NAR);
    p2_nar  = (p2 == NAR);
    spec_c  = p1_zero | p2_zero | p1_nar | p2_nar;
`ifndef POSIT_CORE_DIV_EN
    if (op_s == OP_DIV) spec_c = 1'b1;
`endif
    pout_c = '0;
    if (p1_nar || p2_nar) begin
      pout_c = NAR;
    end else begin
      case (op_s)
        OP_ADD:  pout_c = p1_zero ? p2 : (p2_zero ? p1 : '0);
        OP_SUB:  pout_c = p1_zero ? (-p2) : (p2_zero ? p1 : '0);
        OP_MUL:  pout_c = '0;
`ifdef POSIT_CORE_DIV_EN
        OP_DIV:  pout_c = p2_zero ? NAR : '0;
`else
        OP_DIV:  pout_c = NAR;
`endif
        default: pout_c = '0;
      endcase
    end
    if (!spec_c) pout_c = '0;
  end

  // Normal path: align-and-add/sub, multiply, or divide the mantissas
  always_comb begin
    te1x    = {te1[TE-1], te1};
    te2x    = {te2[TE-1], te2};
    ted     = te1x - te2x;
    op1_big = (te1 > te2) || ((te1 == te2) && (mant1 >= mant2));
    shamt   = ted[TE] ? -ted : ted;
    ext1    = {1'b0, mant1, {(M-1){1'b0}}};
    ext2    = {1'b0, mant2, {(M-1){1'b0}}};
    big     = op1_big ? ext1 : ext2;
    sml     = op1_big ? ext2 : ext1;
    te_big  = op1_big ? te1x : te2x;
    // Shifts at or beyond the full width flush the smaller operand to zero
    sml_sh  = (shamt >= SH_LIM) ? '0 : (sml >> shamt);
    eff_add = ((op_s == OP_ADD) && (s1 == s2)) || ((op_s == OP_SUB) && (s1 != s2));
    prod    = {{M{1'b0}}, mant1} * {{M{1'b0}}, mant2};
`ifdef POSIT_CORE_DIV_EN
    dividend = {mant1, {(2*M-2){1'b0}}};
    divisor  = {{(2*M-2){1'b0}}, mant2};
    quot     = dividend / divisor;
`endif
    sgn_c  = s1 ^ s2;
    te_c   = '0;
    mant_c = '0;
    case (op_s)
      OP_ADD, OP_SUB: begin
        mant_c = eff_add ? (big + sml_sh) : (big - sml_sh);
        te_c   = te_big;
        // Operand 2 in a subtraction contributes with its sign flipped
        sgn_c  = op1_big ? s1 : ((op_s == OP_SUB) ? ~s2 : s2);
        if (!eff_add && (mant_c == '0)) sgn_c = 1'b0;
      end
      OP_MUL: begin
        mant_c = prod;
        te_c   = te1x + te2x;
      end
      OP_DIV: begin
`ifdef POSIT_CORE_DIV_EN
        mant_c = quot[2*M-1:0];
        te_c   = ted;
`else
        mant_c = '0;
        te_c   = '0;
`endif
      end
      default: begin
        mant_c = '0;
        te_c   = '0;
      end
    endcase
  end

  // Capture a new result on in_valid, otherwise hold the last one
  always_comb begin
    res_d = res_q;
    vld_d = in_valid;
    if (in_valid) begin
      res_d.spec = spec_c;
      res_d.pout = pout_c;
      res_d.sgn  = sgn_c;
      res_d.te   = te_c;
      res_d.mant = mant_c;
    end
  end

  // Output register; reset clears everything and drops any pending result
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
    end
  end

  assign out_valid    = vld_q;
  assign is_special   = res_q.spec;
  assign pout_special = res_q.pout;
  assign sign_out     = res_q.sgn;
  assign te_out       = res_q.te;
  assign mant_out     = res_q.mant;

endmodule

// File: tb/tb_posit_special_core.sv
// tb_posit_special_core: scoreboard bench for posit_special_core (N=16, ES=1).
// Expected results are modelled at drive time and compared when out_valid rises.
module tb_posit_special_core;

  localparam int N  = 16;
  localparam int M  = 14;
  localparam int TE = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic [N-1:0]         p1, p2;
  logic [1:0]           op;
  logic signed [TE-1:0] te1, te2;
  logic [M-1:0]         mant1, mant2;
  logic                 out_valid, is_special, sign_out;
  logic [N-1:0]         pout_special;
  logic signed [TE:0]   te_out;
  logic [2*M-1:0]       mant_out;

  posit_special_core #(.N(N), .ES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .p1(p1), .p2(p2), .op(op), .te1(te1), .te2(te2),
    .mant1(mant1), .mant2(mant2),
    .out_valid(out_valid), .is_special(is_special), .pout_special(pout_special),
    .sign_out(sign_out), .te_out(te_out), .mant_out(mant_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        spec;
    logic [15:0] pout;
    logic        full;  // normal-path fields are meaningful
    logic        zn;    // mant/te forced to zero (divider absent)
    logic        sgn;
    int          te;
    longint      mant;
  } exp_t;

  exp_t sbq[$];
  exp_t last;
  int   npass = 0;
  int   ntot  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
    ntot++;
    if (act === expv) npass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, expv);
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o,
                                 input int t1, input int t2, input longint m1, input longint m2);
    exp_t   e;
    logic   az, bz, an, bn, s1, s2, o1big, effadd;
    longint bg, sm;
    int     sh;
    az = (a == 16'h0000); bz = (b == 16'h0000);
    an = (a == 16'h8000); bn = (b == 16'h8000);
    s1 = a[15]; s2 = b[15];
    e.spec = az | bz | an | bn;
    e.pout = 16'h0; e.full = 1'b1; e.zn = 1'b0; e.sgn = 1'b0; e.te = 0; e.mant = 0;
`ifndef POSIT_CORE_DIV_EN
    if (o == 2'b11) begin e.spec = 1'b1; e.zn = 1'b1; end
`endif
    if (e.spec) begin
      e.full = 1'b0;
      if (an || bn) e.pout = 16'h8000;
      else case (o)
        2'b00: e.pout = az ? b : a;
        2'b01: e.pout = az ? (16'h0000 - b) : a;
        2'b10: e.pout = 16'h0000;
        default: begin
`ifdef POSIT_CORE_DIV_EN
          e.pout = bz ? 16'h8000 : 16'h0000;
`else
          e.pout = 16'h8000;
`endif
        end
      endcase
    end
    case (o)
      2'b10: begin e.mant = m1 * m2; e.te = t1 + t2; e.sgn = s1 ^ s2; end
      2'b11: begin
`ifdef POSIT_CORE_DIV_EN
        e.mant = (m1 <<< 26) / m2; e.te = t1 - t2;
`endif
        e.sgn = s1 ^ s2;
      end
      default: begin
        o1big  = (t1 > t2) || ((t1 == t2) && (m1 >= m2));
        bg     = (o1big ? m1 : m2) <<< 13;
        sm     = (o1big ? m2 : m1) <<< 13;
        sh     = (t1 > t2) ? (t1 - t2) : (t2 - t1);
        sm     = (sh >= 28) ? 0 : (sm >>> sh);
        effadd = ((o == 2'b00) && (s1 == s2)) || ((o == 2'b01) && (s1 != s2));
        e.mant = effadd ? (bg + sm) : (bg - sm);
        e.te   = o1big ? t1 : t2;
        e.sgn  = o1big ? s1 : ((o == 2'b01) ? !s2 : s2);
        if (!effadd && e.mant == 0) e.sgn = 1'b0;
      end
    endcase
    return e;
  endfunction

  task automatic cmp(input exp_t e, input string tag);
    chk({tag, ":spec"}, is_special, e.spec);
    chk({tag, ":pout"}, pout_special, e.pout);
    if (e.full) begin
      chk({tag, ":sgn"},  sign_out, e.sgn);
      chk({tag, ":te"},   longint'(te_out), longint'(e.te));
      chk({tag, ":mant"}, mant_out, e.mant);
    end
    if (e.zn) begin
      chk({tag, ":te0"},   longint'(te_out), longint'(e.te));
      chk({tag, ":mant0"}, mant_out, e.mant);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [1:0] o,
                      input int t1, input int t2, input logic [13:0] m1, input logic [13:0] m2,
                      input string tag);
    exp_t e;
    in_valid = v; p1 = a; p2 = b; op = o;
    te1 = 7'(t1); te2 = 7'(t2); mant1 = m1; mant2 = m2;
    if (v) sbq.push_back(model(a, b, o, t1, t2, longint'(m1), longint'(m2)));
    @(posedge clk); #1;
    chk({tag, ":vld"}, out_valid, v);
    if (out_valid) begin
      if (sbq.size() == 0) chk({tag, ":sb"}, out_valid, 1'b0);
      else begin
        e = sbq.pop_front();
        cmp(e, tag);
        last = e;
      end
    end else begin
      cmp(last, {tag, ":hold"});
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; in_valid = 1'b1;
    p1 = 16'h4000; p2 = 16'h4000; op = 2'b10;
    te1 = 7'sd3; te2 = 7'sd1; mant1 = 14'h3000; mant2 = 14'h3000;
    @(posedge clk); #1;
    chk({tag, ":vld"},  out_valid, 1'b0);
    chk({tag, ":spec"}, is_special, 1'b0);
    chk({tag, ":pout"}, pout_special, 16'h0);
    chk({tag, ":sgn"},  sign_out, 1'b0);
    chk({tag, ":te"},   te_out, 8'h0);
    chk({tag, ":mant"}, mant_out, 28'h0);
    rst = 1'b0; in_valid = 1'b0;
    sbq.delete();
    last = '{spec: 1'b0, pout: 16'h0, full: 1'b1, zn: 1'b0, sgn: 1'b0, te: 0, mant: 0};
  endtask

  logic [15:0] ra, rb;

  initial begin
    rst = 1'b1; in_valid = 1'b0; p1 = '0; p2 = '0; op = '0;
    te1 = '0; te2 = '0; mant1 = '0; mant2 = '0;
    do_reset("rst0");
    step(1'b0, 16'h1234, 16'h4321, 2'b00, 5, 2, 14'h2abc, 14'h3111, "idle0");

    // Directed vectors
    step(1'b1, 16'h4000, 16'h4000, 2'b00,  0,  0, 14'h2000, 14'h2000, "add1");
    step(1'b1, 16'h4000, 16'h4000, 2'b10,  1, -2, 14'h3000, 14'h3000, "mul1");
    step(1'b1, 16'h4000, 16'h4000, 2'b01,  3,  3, 14'h2abc, 14'h2abc, "subeq");
    step(1'b0, 16'h0000, 16'h8000, 2'b11,  9, -9, 14'h3fff, 14'h2001, "hold1");
    step(1'b1, 16'h0000, 16'h4000, 2'b01,  0,  0, 14'h2000, 14'h2000, "sp_sub0");
    step(1'b1, 16'h4000, 16'h0000, 2'b11,  0,  0, 14'h2000, 14'h2000, "sp_div0");
    step(1'b1, 16'h8000, 16'h4000, 2'b00,  0,  0, 14'h2000, 14'h2000, "sp_nar");
    step(1'b1, 16'h8000, 16'h0000, 2'b10,  0,  0, 14'h2000, 14'h2000, "sp_narz");
    step(1'b1, 16'h5000, 16'h0000, 2'b00,  0,  0, 14'h2000, 14'h2000, "sp_addp2z");
    step(1'b1, 16'h3000, 16'h0000, 2'b10,  0,  0, 14'h2000, 14'h2000, "sp_mulz");
    step(1'b1, 16'h0000, 16'h3000, 2'b11,  0,  0, 14'h2000, 14'h2000, "sp_div_p1z");
    step(1'b1, 16'h0000, 16'h0000, 2'b11,  0,  0, 14'h2000, 14'h2000, "sp_div00");
    step(1'b1, 16'h4000, 16'h4000, 2'b11,  0,  0, 14'h2000, 14'h2000, "div1");
    step(1'b1, 16'h4800, 16'h3000, 2'b11,  2, -3, 14'h3800, 14'h2400, "div2");
    step(1'b1, 16'h4000, 16'hc000, 2'b01, -1,  2, 14'h2800, 14'h3000, "sub_op2big");
    step(1'b1, 16'h4000, 16'h4000, 2'b01, -1,  2, 14'h2800, 14'h3000, "sub_neg");
    step(1'b1, 16'hc000, 16'h4000, 2'b00,  4,  4, 14'h2000, 14'h3000, "add_mix");
    step(1'b1, 16'h4000, 16'h4000, 2'b00, 20, -8, 14'h2000, 14'h3fff, "sh28");
    step(1'b1, 16'h4000, 16'h4000, 2'b00, 20, -7, 14'h2000, 14'h3fff, "sh27");
    step(1'b1, 16'h4000, 16'h4000, 2'b01, -9, 25, 14'h2100, 14'h3fff, "sh34");

    // Randomized back-to-back traffic with occasional bubbles
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 9) == 0) ra = 16'h0000;
      if ($urandom_range(0, 9) == 0) rb = 16'h8000;
      step(($urandom_range(0, 4) != 0), ra, rb, 2'($urandom_range(0, 3)),
           $urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20,
           14'h2000 | 14'($urandom_range(0, 8191)),
           14'h2000 | 14'($urandom_range(0, 8191)), $sformatf("rnd%0d", i));
    end

    // Reset one cycle after a valid operation
    step(1'b1, 16'h4000, 16'h4000, 2'b10, 1, -2, 14'h3000, 14'h3000, "pre_rst");
    do_reset("rst1");
    step(1'b0, 16'h4000, 16'h4000, 2'b00, 0, 0, 14'h2000, 14'h2000, "post_rst");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
